sram_ws_mem: RTL and testbench
==============================

# sram_ws_mem

Parametrised single-port SRAM behavioural model with valid/ready handshake, per-byte write strobes, configurable wait states and an error response. It is the next-generation bus-slave memory used behind testbench masters and small subsystem models, adding non-power-of-two depth, programmable latency and error signalling to the basic one-cycle SRAM model. The storage array is named `mem` so that `$readmemh`/`$writememh` backdoor tasks can reach it hierarchically.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 40, number of words; any value ≥ 2, need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- WAIT_STATES, 2, extra cycles inserted before `ready`; 0..15
- clk  input  1  clock; all state updates on the rising edge
- res  input  1  reset, asynchronous, active-low
- valid  input  1  request present; held with all request fields until `ready` is sampled high
- wr_rd  input  1  1 = write, 0 = read
- addr  input  ADDR_WIDTH  word address
- wdata  input  WIDTH  write data
- wstrb  input  WIDTH/8  byte write enables; bit n covers wdata[8n+7:8n]
- rdata  output  WIDTH  read data, valid only while `ready`=1 on a read
- ready  output  1  one-cycle completion pulse
- err  output  1  error flag, valid only while `ready`=1

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on rising edge with `valid`=1, capture wr_rd/addr/wdata/wstrb into request registers; go to WAIT with counter = WAIT_STATES if WAIT_STATES>0, else directly to RESP.
- WAIT: counter decrements each edge; at counter==1 edge, go to RESP.
- RESP: `ready`=1 for exactly one cycle; next edge returns to IDLE unconditionally (new requests sampled from the following IDLE cycle).
- Write: performed on the edge entering RESP; only bytes with wstrb=1 updated; wstrb=0 on all bits is a legal no-op write, err=0.
- Read: rdata loaded on the edge entering RESP with mem[addr]; rdata returns to 0 on leaving RESP.
- Out of range (captured addr ≥ DEPTH): write suppressed, rdata=0, err=1.
- `valid` dropped by the master before `ready` (protocol violation): request already captured still completes; no abort.
- Inputs are ignored in WAIT and RESP.

## Timing
- Reset values: ready=0, rdata=0, err=0, state IDLE, counter 0. Array contents are not cleared by reset.
- Reset asserted mid-transaction: FSM returns to IDLE immediately; a write not yet committed is lost; committed writes persist.
- Latency: `ready` high in cycle N+1+WAIT_STATES where N is the cycle `valid` is first sampled in IDLE.
- Throughput: one transaction per WAIT_STATES+2 cycles maximum.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `SRAM_WS_MEM_PARITY_EN` defined: an even-parity bit per byte is stored in array `mem_par` alongside `mem`, written with each strobed byte; on an in-range read, any byte parity mismatch sets err=1 (rdata still returns stored data).
- Not defined: no parity storage; err is raised only for out-of-range addresses.

## Structure
- Package `sram_ws_mem_pkg`: FSM state enum (IDLE, WAIT, RESP), strobe-width constant function WIDTH/8, parity function per byte.
- One sub-module, `sram_array`: storage `mem` (and `mem_par` under the macro), byte-strobed write port, registered read; instantiated as `u_array` so the backdoor path is `dut.u_array.mem`.

## Test plan
- WAIT_STATES=2, write addr 5 data 0xDEADBEEF wstrb 4'hF, then read addr 5 -> `ready` 3 cycles after valid sampled, rdata 0xDEADBEEF, err 0.
- Write addr 7 0x11223344 wstrb F, then write 0xAABBCCDD wstrb 4'b0101, read -> rdata 0x11BB33DD.
- DEPTH=40, read addr 45 and write addr 63 -> err 1, rdata 0, backdoor shows no array change.
- Assert res low during WAIT of a write to addr 3 -> ready stays 0, mem[3] unchanged, next read after release returns prior value.
- WAIT_STATES=0, 40 back-to-back frontdoor writes then reads over all addresses -> every read matches, one transaction per 2 cycles.
- With SRAM_WS_MEM_PARITY_EN: write addr 9, flip one bit of `dut.u_array.mem[9]` via backdoor, read -> err 1, rdata shows corrupted word; without macro same stimulus -> err 0.

Source files
------------

// File: rtl/sram_ws_mem_pkg.sv
// Shared types and helpers for the wait-state SRAM model.
package sram_ws_mem_pkg;

  // Request life cycle: idle, counting wait states, one-cycle response
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Number of byte lanes in a data word
  function automatic int unsigned strb_width(input int unsigned width);
    return width / 8;
  endfunction

  // Even-parity bit for one byte: data plus parity carries an even number of ones
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Storage array for sram_ws_mem: byte-strobed write port and registered read.
// The array is named mem so backdoor loads can reach it hierarchically.
// Optional macro SRAM_WS_MEM_PARITY_EN adds a per-byte even-parity array mem_par.
module sram_array
  import sram_ws_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 40,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            we_i,
  input  logic                            re_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic [strb_width(WIDTH)-1:0]    wstrb_i,
  output logic [WIDTH-1:0]                rdata_o,
  output logic                            perr_o
);

  localparam int unsigned StrbW = strb_width(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Byte-strobed write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read data is nonzero only in the cycle after a load
  always_comb begin
    rdata_d = '0;
    if (re_i) rdata_d = mem[addr_i];
  end

  // Registered read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

`ifdef SRAM_WS_MEM_PARITY_EN
  logic [StrbW-1:0] mem_par [DEPTH];

  // Parity bits follow their data bytes
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb_i[i]) mem_par[addr_i][i] <= byte_parity(wdata_i[8*i +: 8]);
      end
    end
  end

  // Combinational parity check of the addressed word; caller qualifies it
  always_comb begin
    perr_o = 1'b0;
    for (int i = 0; i < StrbW; i++) begin
      if (byte_parity(mem[addr_i][8*i +: 8]) != mem_par[addr_i][i]) perr_o = 1'b1;
    end
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/sram_ws_mem.sv
// Single-port SRAM bus slave with valid/ready handshake, byte strobes,
// WAIT_STATES extra cycles of latency and an error response for out-of-range
// addresses. Macro SRAM_WS_MEM_PARITY_EN enables per-byte parity checking.
module sram_ws_mem
  import sram_ws_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 40,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         valid,
  input  logic                         wr_rd,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [strb_width(WIDTH)-1:0] wstrb,
  output logic [WIDTH-1:0]             rdata,
  output logic                         ready,
  output logic                         err
);

  localparam int unsigned StrbW    = strb_width(WIDTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    enter_resp;

  logic                    op_wr;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [WIDTH-1:0]        op_wdata;
  logic [StrbW-1:0]        op_wstrb;
  logic                    in_range;
  logic                    arr_we, arr_re, arr_perr;

  // Next-state logic: capture in idle, count wait states, single response cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          wr_d    = wr_rd;
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With no wait states the commit edge is the capture edge, so use live inputs
  always_comb begin
    op_wr    = wr_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_wstrb = wstrb_q;
    if (state_q == StIdle) begin
      op_wr    = wr_rd;
      op_addr  = addr;
      op_wdata = wdata;
      op_wstrb = wstrb;
    end
  end

  // Response decode on the edge entering the response state
  always_comb begin
    in_range = ({1'b0, op_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    arr_we   = enter_resp & op_wr & in_range & res;
    arr_re   = enter_resp & ~op_wr & in_range;
    ready_d  = enter_resp;
    err_d    = enter_resp & (~in_range | (~op_wr & arr_perr));
  end

  // State, request and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  sram_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (res),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (op_addr),
    .wdata_i (op_wdata),
    .wstrb_i (op_wstrb),
    .rdata_o (rdata),
    .perr_o  (arr_perr)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sram_ws_mem.sv
// Scoreboard bench for sram_ws_mem: one instance with two wait states, one with none.
module tb_sram_ws_mem;

  localparam int D  = 40;
  localparam int AW = 6;

`ifdef SRAM_WS_MEM_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic          v2, wr2, rdy2, er2;
  logic [AW-1:0] a2;
  logic [31:0]   wd2, rd2;
  logic [3:0]    s2;
  logic          v0, wr0, rdy0, er0;
  logic [AW-1:0] a0;
  logic [31:0]   wd0, rd0;
  logic [3:0]    s0;

  sram_ws_mem #(.WIDTH(32), .DEPTH(D), .WAIT_STATES(2)) dut (
    .clk(clk), .res(res), .valid(v2), .wr_rd(wr2), .addr(a2), .wdata(wd2),
    .wstrb(s2), .rdata(rd2), .ready(rdy2), .err(er2)
  );

  sram_ws_mem #(.WIDTH(32), .DEPTH(D), .WAIT_STATES(0)) dut0 (
    .clk(clk), .res(res), .valid(v0), .wr_rd(wr0), .addr(a0), .wdata(wd0),
    .wstrb(s0), .rdata(rd0), .ready(rdy0), .err(er0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] model[2][D];
  logic [3:0]  bad[D];   // bytes of dut's array corrupted by backdoor
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor for the two-wait-state instance
  always @(negedge clk) begin
    if (rdy2 === 1'b1) begin
      exp_t e;
      if (q2.size() == 0) begin
        check("ws2_unexpected_ready", 32'(rdy2), 32'd0);
      end else begin
        e = q2.pop_front();
        check("ws2_rdata", rd2, e.rdata);
        check("ws2_err", {31'b0, er2}, {31'b0, e.err});
        check("ws2_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Monitor for the zero-wait-state instance
  always @(negedge clk) begin
    if (rdy0 === 1'b1) begin
      exp_t e;
      if (q0.size() == 0) begin
        check("ws0_unexpected_ready", 32'(rdy0), 32'd0);
      end else begin
        e = q0.pop_front();
        check("ws0_rdata", rd0, e.rdata);
        check("ws0_err", {31'b0, er0}, {31'b0, e.err});
        check("ws0_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One transaction; called #1 after a rising edge with the target idle
  task automatic txn(input int sel, input logic wr, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    exp_t        e;
    logic [31:0] m;
    logic        seen;
    if (sel == 1) begin
      v2 = 1'b1; wr2 = wr; a2 = a; wd2 = d; s2 = s;
    end else begin
      v0 = 1'b1; wr0 = wr; a0 = a; wd0 = d; s0 = s;
    end
    @(posedge clk);
    #1;
    if (sel == 1) v2 = 1'b0;
    else          v0 = 1'b0;
    e.cyc   = cyc + ((sel == 1) ? 2 : 0);
    e.rdata = '0;
    e.err   = 1'b0;
    if (int'(a) >= D) begin
      e.err = 1'b1;
    end else if (wr) begin
      m = '0;
      for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
      model[sel][a] = (model[sel][a] & ~m) | (d & m);
      if (sel == 1) bad[a] = bad[a] & ~s;
    end else begin
      e.rdata = model[sel][a];
      if (sel == 1 && ParEn) e.err = |bad[a];
    end
    if (sel == 1) q2.push_back(e);
    else          q0.push_back(e);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (sel == 1) ? (rdy2 === 1'b1) : (rdy0 === 1'b1);
    end
    check("handshake_done", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b0;
    v2 = 0; wr2 = 0; a2 = '0; wd2 = '0; s2 = '0;
    v0 = 0; wr0 = 0; a0 = '0; wd0 = '0; s0 = '0;
    for (int i = 0; i < D; i++) bad[i] = 4'h0;
    #2;
    check("reset_ready", {31'b0, rdy2}, 32'd0);
    check("reset_err", {31'b0, er2}, 32'd0);
    check("reset_rdata", rd2, 32'd0);
    check("reset_ready_ws0", {31'b0, rdy0}, 32'd0);
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait-state instance: back-to-back writes then reads of every word
    for (int i = 0; i < D; i++) txn(0, 1'b1, AW'(i), $urandom, 4'hF);
    for (int i = 0; i < D; i++) txn(0, 1'b0, AW'(i), 32'd0, 4'h0);

    // Two-wait-state instance: fill array so every read has a known value
    for (int i = 0; i < D; i++) txn(1, 1'b1, AW'(i), $urandom, 4'hF);

    txn(1, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    txn(1, 1'b0, 6'd5, 32'd0, 4'h0);
    txn(1, 1'b1, 6'd7, 32'h11223344, 4'hF);
    txn(1, 1'b1, 6'd7, 32'hAABBCCDD, 4'b0101);
    txn(1, 1'b0, 6'd7, 32'd0, 4'h0);
    check("partial_write_value", model[1][7], 32'h11BB33DD);
    txn(1, 1'b1, 6'd8, 32'h55667788, 4'h0);
    txn(1, 1'b0, 6'd8, 32'd0, 4'h0);

    // Out-of-range accesses leave the array untouched
    txn(1, 1'b0, 6'd45, 32'd0, 4'h0);
    txn(1, 1'b1, 6'd63, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < D; i++) check("backdoor_after_oor", dut.u_array.mem[i], model[1][i]);

    // Reset during the wait of a write to word 3 loses that write
    v2 = 1'b1; wr2 = 1'b1; a2 = 6'd3; wd2 = 32'h0BADF00D; s2 = 4'hF;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    res = 1'b0;
    #1;
    check("reset_mid_ready", {31'b0, rdy2}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_mid_ready_held", {31'b0, rdy2}, 32'd0);
    check("reset_mid_mem3", dut.u_array.mem[3], model[1][3]);
    res = 1'b1;
    @(posedge clk);
    #1;
    txn(1, 1'b0, 6'd3, 32'd0, 4'h0);

    // Backdoor bit flip in word 9 is visible as data, and as an error with parity
    txn(1, 1'b1, 6'd9, 32'hCAFE1234, 4'hF);
    dut.u_array.mem[9] = dut.u_array.mem[9] ^ 32'h0000_0100;
    model[1][9] = model[1][9] ^ 32'h0000_0100;
    bad[9] = bad[9] | 4'b0010;
    txn(1, 1'b0, 6'd9, 32'd0, 4'h0);
    txn(1, 1'b1, 6'd9, 32'h0000_5500, 4'b0010);
    txn(1, 1'b0, 6'd9, 32'd0, 4'h0);

    // Random traffic over in-range and out-of-range addresses on both instances
    for (int n = 0; n < 60; n++) begin
      txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
          4'($urandom));
    end
    for (int n = 0; n < 30; n++) begin
      txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
          4'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained_ws2", 32'(q2.size()), 32'd0);
    check("scoreboard_drained_ws0", 32'(q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
